// File: rtl/systolic_pkg.sv
// Shared sizing and scheduler state encoding for the 2x2 systolic tile scheduler
// and the systolictop array it drives.
package systolic_pkg;
  localparam int DATA_W    = 8;
  localparam int N         = 8;
  localparam int ACC_W     = 2 * DATA_W;
  localparam int DRAIN_CYC = 2;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    FEED,
    DRAIN,
    WRITE,
    DONE
  } state_e;
endpackage

// File: rtl/systolic_skew.sv
// One-cycle delay of the second-row/second-column operand pair; a synchronous
// zero-load flushes it so stale data never leaks into the next tile.
module systolic_skew
  import systolic_pkg::*;
#(
  parameter int DATA_W = systolic_pkg::DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                zero_i,
  input  logic [2*DATA_W-1:0] d_i,
  output logic [2*DATA_W-1:0] q_o
);

  logic [2*DATA_W-1:0] skew_q;
  logic [2*DATA_W-1:0] skew_d;

  always_comb begin
    skew_d = zero_i ? '0 : d_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) skew_q <= '0;
    else       skew_q <= skew_d;
  end

  assign q_o = skew_q;

endmodule

// File: rtl/systolic_tile_sched.sv
// Walks an NxN matrix product as 2x2 output tiles, streaming skewed operand
// pairs from the A/B read ports into a 2x2 systolic array and writing results.
module systolic_tile_sched
  import systolic_pkg::*;
#(
  parameter int DATA_W    = systolic_pkg::DATA_W,
  parameter int N         = systolic_pkg::N,
  parameter int ACC_W     = 2 * DATA_W,
  parameter int DRAIN_CYC = systolic_pkg::DRAIN_CYC,
  localparam int IW       = $clog2(N),
  localparam int AW       = 2 * IW
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic [AW-1:0]       a_rd_addr,
  input  logic [2*DATA_W-1:0] a_rd_data,
  output logic [AW-1:0]       b_rd_addr,
  input  logic [2*DATA_W-1:0] b_rd_data,
  output logic [DATA_W-1:0]   a1,
  output logic [DATA_W-1:0]   a2,
  output logic [DATA_W-1:0]   b1,
  output logic [DATA_W-1:0]   b2,
  output logic                clr_acc,
  input  logic [ACC_W-1:0]    c1,
  input  logic [ACC_W-1:0]    c2,
  input  logic [ACC_W-1:0]    c3,
  input  logic [ACC_W-1:0]    c4,
  output logic                res_we,
  output logic [AW-1:0]       res_addr,
  output logic [4*ACC_W-1:0]  res_data,
  output logic                busy,
  output logic                done
);

  localparam int FW = $clog2(N + 1);
  localparam int DW = $clog2(DRAIN_CYC + 2);
  localparam logic [FW-1:0] F_LAST    = FW'(N);
  localparam logic [FW-1:0] F_RD_LAST = FW'(N - 2);
  localparam logic [DW-1:0] D_LAST    = DW'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);
  localparam logic [IW-1:0] T_LAST    = IW'(N - 2);

  state_e        state_q, state_d;
  logic [FW-1:0] f_q, f_d;
  logic [DW-1:0] d_q, d_d;
  logic [IW-1:0] i_q, i_d;
  logic [IW-1:0] j_q, j_d;

  logic                in_feed;
  logic                lo_vld;
  logic                rd_en;
  logic [IW-1:0]       k_rd;
  logic [2*DATA_W-1:0] skew_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      f_q     <= '0;
      d_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      f_q     <= f_d;
      d_q     <= d_d;
      i_q     <= i_d;
      j_q     <= j_d;
    end
  end

  always_comb begin
    state_d = state_q;
    f_d     = f_q;
    d_d     = d_q;
    i_d     = i_q;
    j_d     = j_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          i_d     = '0;
          j_d     = '0;
        end
      end
      FETCH: begin
        state_d = FEED;
        f_d     = '0;
      end
      FEED: begin
        if (f_q == F_LAST) begin
          f_d     = '0;
          d_d     = '0;
          state_d = (DRAIN_CYC == 0) ? WRITE : DRAIN;
        end else begin
          f_d = f_q + FW'(1);
        end
      end
      DRAIN: begin
        if (d_q == D_LAST) begin
          d_d     = '0;
          state_d = WRITE;
        end else begin
          d_d = d_q + DW'(1);
        end
      end
      WRITE: begin
        if (i_q == T_LAST && j_q == T_LAST) begin
          state_d = DONE;
        end else begin
          state_d = FETCH;
          if (j_q == T_LAST) begin
            j_d = '0;
            i_d = i_q + IW'(2);
          end else begin
            j_d = j_q + IW'(2);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reads run one k ahead of the operands because the ports have one cycle of latency.
  always_comb begin
    in_feed = (state_q == FEED);
    lo_vld  = in_feed && (f_q != F_LAST);
    rd_en   = (state_q == FETCH) || (in_feed && (f_q <= F_RD_LAST));
    k_rd    = (state_q == FETCH) ? '0 : IW'(f_q + FW'(1));
  end

  systolic_skew #(
    .DATA_W(DATA_W)
  ) u_skew (
    .clk   (clk),
    .reset (reset),
    .zero_i(~lo_vld),
    .d_i   ({a_rd_data[2*DATA_W-1:DATA_W], b_rd_data[2*DATA_W-1:DATA_W]}),
    .q_o   (skew_q)
  );

  always_comb begin
    a_rd_addr = rd_en ? {i_q, k_rd} : '0;
    b_rd_addr = rd_en ? {k_rd, j_q} : '0;
    a1        = lo_vld ? a_rd_data[DATA_W-1:0] : '0;
    b1        = lo_vld ? b_rd_data[DATA_W-1:0] : '0;
    a2        = in_feed ? skew_q[2*DATA_W-1:DATA_W] : '0;
    b2        = in_feed ? skew_q[DATA_W-1:0] : '0;
    clr_acc   = (state_q == FETCH);
    res_we    = (state_q == WRITE);
    res_addr  = res_we ? AW'(int'(i_q) * N + int'(j_q)) : '0;
    res_data  = res_we ? {c4, c3, c2, c1} : '0;
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
  end

endmodule
